// File: rtl/periph_req_scheduler.sv
// Round-robin scheduler that shares the SoC peripheral space between requesters,
// decodes the winner's address to a one-hot select and runs one request/ack exchange at a time.
module periph_req_scheduler #(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned NumPeriph     = 11,
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned DataWidth     = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq*AddrWidth-1:0]   addr_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rsp_valid_o,
   output logic                          rsp_err_o,
   output logic [DataWidth-1:0]          rsp_rdata_o,
   output logic                          p_req_o,
   output logic [NumPeriph-1:0]          p_sel_o,
   output logic [AddrWidth-1:0]          p_addr_o,
   output logic                          p_we_o,
   output logic [DataWidth-1:0]          p_wdata_o,
   input  logic                          p_ack_i,
   input  logic [DataWidth-1:0]          p_rdata_i
);

   localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

   // Memory map indexed by select bit (DRAM = 0 ... Debug = 10); LlcSpm is deliberately absent.
   localparam logic [63:0] PeriphBase [11] = '{
      64'h0000_0000_8000_0000, 64'h0000_0000_5000_0000, 64'h0000_0000_4000_0000,
      64'h0000_0000_3000_0000, 64'h0000_0000_2000_0000, 64'h0000_0000_1800_0000,
      64'h0000_0000_1000_0000, 64'h0000_0000_0C00_0000, 64'h0000_0000_0200_0000,
      64'h0000_0000_0001_0000, 64'h0000_0000_0000_0000
   };
   localparam logic [63:0] PeriphLen [11] = '{
      64'h0000_0000_4000_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000,
      64'h0000_0000_0001_0000, 64'h0000_0000_0080_0000, 64'h0000_0000_0000_1000,
      64'h0000_0000_0000_1000, 64'h0000_0000_03FF_FFFF, 64'h0000_0000_000C_0000,
      64'h0000_0000_0001_0000, 64'h0000_0000_0000_1000
   };

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e                 state_q, state_d;
   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic [PtrW-1:0]        win_q, win_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic                   we_q, we_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [NumPeriph-1:0]   sel_q, sel_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;

   logic [AddrWidth-1:0]   req_addr  [NumReq];
   logic [DataWidth-1:0]   req_wdata [NumReq];
   logic                   arb_found;
   logic [PtrW-1:0]        arb_idx;
   logic [63:0]            win_addr;
   logic [NumPeriph-1:0]   dec_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NumReq; gi++) begin : g_unpack
         assign req_addr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
         assign req_wdata[gi] = wdata_i[gi*DataWidth +: DataWidth];
      end
   endgenerate

   // First set request at or after the pointer, wrapping around.
   always_comb begin
      logic [PtrW:0] sum;
      arb_found = 1'b0;
      arb_idx   = '0;
      sum       = '0;
      for (int i = 0; i < NumReq; i++) begin
         sum = {1'b0, ptr_q} + (PtrW+1)'(i);
         if (sum >= (PtrW+1)'(NumReq)) begin
            sum = sum - (PtrW+1)'(NumReq);
         end
         if (!arb_found && req_i[sum[PtrW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = sum[PtrW-1:0];
         end
      end
   end

   assign win_addr = 64'(req_addr[arb_idx]);

   // Subtract-then-compare keeps base+length from ever overflowing.
   generate
      for (gi = 0; gi < NumPeriph; gi++) begin : g_dec
         assign dec_sel[gi] = (win_addr >= PeriphBase[gi]) &&
                              ((win_addr - PeriphBase[gi]) < PeriphLen[gi]);
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      gnt_o       = '0;
      rsp_valid_o = '0;
      p_req_o     = 1'b0;
      p_sel_o     = '0;
      unique case (state_q)
         IDLE: begin
            if (arb_found) begin
               gnt_o[arb_idx] = 1'b1;
               win_d          = arb_idx;
               ptr_d          = (arb_idx == PtrW'(NumReq - 1)) ? '0 : arb_idx + PtrW'(1);
               addr_d         = req_addr[arb_idx];
               we_d           = we_i[arb_idx];
               wdata_d        = req_wdata[arb_idx];
               sel_d          = dec_sel;
               cnt_d          = '0;
               if (|dec_sel) begin
                  state_d = BUSY;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         BUSY: begin
            p_req_o = 1'b1;
            p_sel_o = sel_q;
            // An ack landing on the timeout cycle still wins.
            if (p_ack_i) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : p_rdata_i;
            end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RESP: begin
            rsp_valid_o[win_q] = 1'b1;
            state_d            = IDLE;
            cnt_d              = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign rsp_err_o   = err_q;
   assign rsp_rdata_o = rdata_q;
   assign p_addr_o    = addr_q;
   assign p_we_o      = we_q;
   assign p_wdata_o   = wdata_q;

endmodule

// File: tb/tb_periph_req_scheduler.sv
// Scoreboard bench: expected responses are queued as stimulus is driven and
// popped by a monitor whenever the scheduler pulses rsp_valid_o.
module tb_periph_req_scheduler;

   localparam int TO = 4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [1:0]   req_i;
   logic [127:0] addr_i;
   logic [1:0]   we_i;
   logic [127:0] wdata_i;
   logic [1:0]   gnt_o;
   logic [1:0]   rsp_valid_o;
   logic         rsp_err_o;
   logic [63:0]  rsp_rdata_o;
   logic         p_req_o;
   logic [10:0]  p_sel_o;
   logic [63:0]  p_addr_o;
   logic         p_we_o;
   logic [63:0]  p_wdata_o;
   logic         p_ack_i;
   logic [63:0]  p_rdata_i;

   periph_req_scheduler #(
      .NumReq(2), .NumPeriph(11), .TimeoutCycles(TO), .AddrWidth(64), .DataWidth(64)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
      .rsp_rdata_o(rsp_rdata_o), .p_req_o(p_req_o), .p_sel_o(p_sel_o), .p_addr_o(p_addr_o),
      .p_we_o(p_we_o), .p_wdata_o(p_wdata_o), .p_ack_i(p_ack_i), .p_rdata_i(p_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          r;
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   exp_t q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   rsp_cnt   = 0;
   int   push_cnt  = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int r, input logic err, input logic [63:0] rd);
      exp_t e;
      e.r     = r;
      e.err   = err;
      e.rdata = rd;
      q.push_back(e);
      push_cnt++;
   endtask

   // Reference decode written as a plain range table (bit index = axi_slaves_t value).
   function automatic logic [10:0] ref_sel(input logic [63:0] a);
      logic [63:0] base [11];
      logic [63:0] len  [11];
      logic [10:0] s;
      base = '{64'h8000_0000, 64'h5000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
               64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0};
      len  = '{64'h4000_0000, 64'h1000, 64'h1000, 64'h1_0000, 64'h80_0000,
               64'h1000, 64'h1000, 64'h3FF_FFFF, 64'hC_0000, 64'h1_0000, 64'h1000};
      s = '0;
      for (int i = 0; i < 11; i++) begin
         if (a >= base[i] && a < base[i] + len[i]) s[i] = 1'b1;
      end
      return s;
   endfunction

   always @(negedge clk_i) begin
      exp_t e;
      if (rsp_valid_o != 2'b00) begin
         rsp_cnt++;
         $display("TXN rsp valid=%b err=%0b rdata=%h", rsp_valid_o, rsp_err_o, rsp_rdata_o);
         if (q.size() == 0) begin
            check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
         end else begin
            e = q.pop_front();
            check_eq("rsp_valid", 64'(rsp_valid_o), 64'(2'b01 << e.r));
            check_eq("rsp_err", 64'(rsp_err_o), 64'(e.err));
            check_eq("rsp_rdata", rsp_rdata_o, e.rdata);
         end
      end
   end

   // ack_cyc counts BUSY cycles from 0; negative means never ack.
   task automatic run_txn(input int r, input logic [63:0] addr, input logic we,
                          input logic [63:0] wd, input int ack_cyc, input logic [63:0] rd);
      logic [10:0] esel;
      logic        ack_now;
      esel = ref_sel(addr);
      @(posedge clk_i); #1;
      req_i                = 2'(2'b01 << r);
      addr_i[r*64 +: 64]   = addr;
      we_i[r]              = we;
      wdata_i[r*64 +: 64]  = wd;
      if (esel == '0) push_exp(r, 1'b1, 64'd0);
      @(negedge clk_i);
      check_eq("gnt", 64'(gnt_o), 64'(2'b01 << r));
      @(posedge clk_i); #1;
      req_i = 2'b00;
      if (esel != '0) begin
         for (int c = 0; c < TO; c++) begin
            ack_now = (c == ack_cyc);
            if (ack_now) begin
               p_ack_i   = 1'b1;
               p_rdata_i = rd;
               push_exp(r, 1'b0, we ? 64'd0 : rd);
            end else if (c == TO - 1) begin
               push_exp(r, 1'b1, 64'd0);
            end
            @(negedge clk_i);
            check_eq("busy_p_req", 64'(p_req_o), 64'd1);
            check_eq("busy_p_sel", 64'(p_sel_o), 64'(esel));
            check_eq("busy_p_addr", p_addr_o, addr);
            check_eq("busy_p_we", 64'(p_we_o), 64'(we));
            if (we) check_eq("busy_p_wdata", p_wdata_o, wd);
            check_eq("busy_no_rsp", 64'(rsp_valid_o), 64'd0);
            @(posedge clk_i); #1;
            p_ack_i   = 1'b0;
            p_rdata_i = 64'hFFFF_0000_DEAD_0BAD;
            if (ack_now) break;
         end
      end
      @(negedge clk_i);
      check_eq("resp_p_req", 64'(p_req_o), 64'd0);
      check_eq("resp_p_sel", 64'(p_sel_o), 64'd0);
      @(posedge clk_i); #1;
      check_eq("rsp_count", 64'(rsp_cnt), 64'(push_cnt));
      check_eq("q_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i     = 1'b1;
      req_i     = '0;
      addr_i    = '0;
      we_i      = '0;
      wdata_i   = '0;
      p_ack_i   = 1'b0;
      p_rdata_i = 64'hFFFF_0000_DEAD_0BAD;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_eq("rst_gnt", 64'(gnt_o), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check_eq("rst_rsp_err", 64'(rsp_err_o), 64'd0);
      check_eq("rst_rsp_rdata", rsp_rdata_o, 64'd0);
      check_eq("rst_p_req", 64'(p_req_o), 64'd0);
      check_eq("rst_p_sel", 64'(p_sel_o), 64'd0);
      check_eq("rst_p_addr", p_addr_o, 64'd0);
      check_eq("rst_p_we", 64'(p_we_o), 64'd0);
      check_eq("rst_p_wdata", p_wdata_o, 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      run_txn(0, 64'h1000_0008, 1'b0, 64'd0, 2, 64'hDEAD);           // UART read
      run_txn(1, 64'h6000_0000, 1'b0, 64'd0, 0, 64'd0);              // LlcSpm miss
      run_txn(0, 64'hBFFF_FFF8, 1'b1, 64'h1122_3344_5566_7788, 1, 64'h55AA); // DRAM top write
      run_txn(1, 64'hC000_0000, 1'b0, 64'd0, 0, 64'd0);              // just past DRAM
      run_txn(0, 64'h0, 1'b0, 64'd0, -1, 64'd0);                     // Debug timeout
      run_txn(1, 64'h8, 1'b0, 64'd0, TO - 1, 64'hBEEF);              // ack on timeout cycle
      run_txn(0, 64'h0C00_0010, 1'b0, 64'd0, 0, 64'h0123_4567_89AB_CDEF); // PLIC
      run_txn(1, 64'h3000_FFFF, 1'b0, 64'd0, 0, 64'h77);             // Ethernet last byte
      run_txn(0, 64'h1000, 1'b0, 64'd0, 0, 64'd0);                   // gap after Debug
      run_txn(1, 64'h5000_0FFF, 1'b1, 64'hCAFE, 0, 64'h99);          // LlcCfg write

      // Reset while BUSY abandons the transaction.
      @(posedge clk_i); #1;
      req_i            = 2'b01;
      addr_i[63:0]     = 64'h1000_0000;
      we_i             = 2'b00;
      @(negedge clk_i);
      check_eq("rstb_gnt", 64'(gnt_o), 64'd1);
      @(posedge clk_i); #1;
      req_i = 2'b00;
      rst_i = 1'b1;
      @(negedge clk_i);
      check_eq("rstb_busy", 64'(p_req_o), 64'd1);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_eq("rstb_p_req", 64'(p_req_o), 64'd0);
      check_eq("rstb_no_rsp", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      check_eq("rstb_no_rsp2", 64'(rsp_valid_o), 64'd0);

      // Round-robin with both held and immediate acks; pointer must restart at 0.
      @(posedge clk_i); #1;
      addr_i    = {64'h1000_0010, 64'h1000_0020};
      we_i      = 2'b00;
      p_ack_i   = 1'b1;
      p_rdata_i = 64'h1234;
      req_i     = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         check_eq("rr_gnt", 64'(gnt_o), 64'(2'b01 << (k % 2)));
         push_exp(k % 2, 1'b0, 64'h1234);
         @(negedge clk_i);
         check_eq("rr_busy", 64'(p_req_o), 64'd1);
         @(negedge clk_i);
         check_eq("rr_resp_gnt", 64'(gnt_o), 64'd0);
      end
      @(posedge clk_i); #1;
      req_i     = 2'b00;
      p_ack_i   = 1'b0;
      p_rdata_i = 64'hFFFF_0000_DEAD_0BAD;
      check_eq("rr_count", 64'(rsp_cnt), 64'(push_cnt));

      run_txn(1, 64'h1000_0000, 1'b0, 64'd0, 0, 64'hCAFE);           // req1 alone after reset

      repeat (3) @(posedge clk_i);
      check_eq("final_q", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
